axs_wr_fsm: RTL and testbench
=============================

Name: axs_wr_fsm

Overview:
AXI4 write-channel slave controller; the write-side counterpart of the read-channel responder. It accepts one AW burst, streams W beats into the inbound FIFO, then returns a B response. It sits between the AXI4 slave port s0 and the inbound data FIFO. W data bits travel straight from the port to the FIFO; this block generates only control, per-beat address and the response.

Parameters:
ID_W, 4, AWID/BID width
ADDR_W, 32, address width
LEN_W, 8, AWLEN width (beats = awlen+1)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
axs_s0_awid  in  ID_W  write ID
axs_s0_awaddr  in  ADDR_W  burst start address
axs_s0_awlen  in  LEN_W  beats minus one
axs_s0_awsize  in  3  log2 bytes per beat
axs_s0_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
axs_s0_awvalid  in  1  AW valid
axs_s0_awready  out  1  AW ready
axs_s0_wlast  in  1  master last-beat flag
axs_s0_wvalid  in  1  W valid
axs_s0_wready  out  1  W ready
axs_s0_bid  out  ID_W  response ID
axs_s0_bresp  out  2  00 OKAY, 10 SLVERR
axs_s0_bvalid  out  1  B valid
axs_s0_bready  in  1  B ready
in_fifo_full  in  1  inbound FIFO full
in_fifo_push  out  1  push current W beat
in_fifo_addr  out  ADDR_W  address of current beat

Behaviour:
- Reset is asynchronous and active-high. It forces state INIT and clears every register. During reset: awready=0, wready=0, bvalid=0, push=0, bid=0, bresp=00, in_fifo_addr=0.
- One-hot states: INIT, AW_READY, W_ACCEPT, B_VALID.
- INIT: clear registers; next state is AW_READY unconditionally.
- AW_READY: awready=1.
  - On awvalid: latch id, addr, len, size and burst; load beat counter = awlen; clear err; go to W_ACCEPT.
  - If burst=11, set err.
- W_ACCEPT: wready = ~in_fifo_full (combinational).
  - in_fifo_push = wvalid & wready, in the same cycle.
  - in_fifo_addr = current beat address register.
  - On an accepted beat with counter==0: go to B_VALID.
  - Otherwise: decrement the counter and advance the address.
  - While full, hold state; no beat is lost.
- Address advance, with step = 1<<size:
  - FIXED: unchanged.
  - INCR: addr + step, modulo 2^ADDR_W.
  - WRAP: wrap length = (len+1)*step. New address = (addr & ~(wrap length-1)) | ((addr+step) & (wrap length-1)).
  - Reserved: unchanged.
- B_VALID: bvalid=1, bid = latched id, bresp = err ? 10 : 00. Go to AW_READY only when bready=1; hold otherwise.
- Single outstanding burst. awready=0 outside AW_READY, so an AW arriving during W or B waits.
- W beats presented before the AW handshake are not accepted (wready=0).
- Illegal state encoding: next state INIT.
- Latency:
  - AW handshake to first possible wready: 1 cycle.
  - Last W beat to bvalid: 1 cycle.
  - B handshake to awready: 1 cycle.

Optional Feature:
WLAST_CHECK_EN.
- Defined: on each accepted beat, compare wlast with (counter==0). Any mismatch sets err, giving a SLVERR response.
- Not defined: wlast is ignored; burst length comes from awlen alone; err is set only by the reserved burst type.

Decomposition:
- Package axs_wr_pkg holds:
  - state encodings (8-bit one-hot, matching the read FSM style);
  - burst type constants;
  - response constants OKAY and SLVERR.
- One sub-module axs_burst_addr: combinational next-address logic. Inputs addr, size, len, burst; output next_addr.

Test Plan:
- INCR single beat (awaddr=0x100, awlen=0, awsize=2) -> 1 push, addr 0x100; bvalid one cycle later with bid=awid and bresp=00.
- INCR 4 beats (0x1000, awsize=2, awlen=3) -> push addresses 0x1000, 0x1004, 0x1008, 0x100C; one B response.
- WRAP 4 beats (0x1008, awsize=2) -> push addresses 0x1008, 0x100C, 0x1000, 0x1004.
- in_fifo_full asserted 3 cycles mid-burst with wvalid held -> wready=0 and push=0 for those 3 cycles; all beats pushed exactly once.
- bready held low 5 cycles -> bvalid, bid and bresp stable; awready stays 0 until the B handshake.
- With WLAST_CHECK_EN and awlen=3: wlast on beat 2 -> bresp=10. Separately, burst=11 -> bresp=10. Asserting reset mid-burst -> all outputs 0 immediately, then the block returns to AW_READY.

Source files
------------

// File: rtl/axs_wr_pkg.sv
// Shared encodings for the AXI4 write-channel slave controller (axs_wr_fsm).
package axs_wr_pkg;

  typedef enum logic [7:0] {
    ST_INIT      = 8'h01,
    ST_AW_READY  = 8'h02,
    ST_W_ACCEPT  = 8'h04,
    ST_B_VALID   = 8'h08
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axs_burst_addr.sv
// Combinational next-beat address for FIXED / INCR / WRAP bursts; reserved holds.
module axs_burst_addr
  import axs_wr_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        size,
  input  logic [LEN_W-1:0]  len,
  input  logic [1:0]        burst,
  output logic [ADDR_W-1:0] next_addr
);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] wrap_len;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] incr_addr;

  assign step      = ADDR_W'(1) << size;
  assign wrap_len  = (ADDR_W'(len) + ADDR_W'(1)) << size;
  assign wrap_mask = wrap_len - ADDR_W'(1);
  assign incr_addr = addr + step;

  always_comb begin
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      // Keep the upper bits of the wrap window, roll the offset within it.
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axs_wr_fsm.sv
// AXI4 write-channel slave controller: one AW burst, W beats into the inbound FIFO, one B.
// Optional macro WLAST_CHECK_EN: flag SLVERR when wlast disagrees with the beat count.
module axs_wr_fsm
  import axs_wr_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ID_W-1:0]   axs_s0_awid,
  input  logic [ADDR_W-1:0] axs_s0_awaddr,
  input  logic [LEN_W-1:0]  axs_s0_awlen,
  input  logic [2:0]        axs_s0_awsize,
  input  logic [1:0]        axs_s0_awburst,
  input  logic              axs_s0_awvalid,
  output logic              axs_s0_awready,
  input  logic              axs_s0_wlast,
  input  logic              axs_s0_wvalid,
  output logic              axs_s0_wready,
  output logic [ID_W-1:0]   axs_s0_bid,
  output logic [1:0]        axs_s0_bresp,
  output logic              axs_s0_bvalid,
  input  logic              axs_s0_bready,
  input  logic              in_fifo_full,
  output logic              in_fifo_push,
  output logic [ADDR_W-1:0] in_fifo_addr
);

  state_e            state_q;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q;
  logic [ADDR_W-1:0] next_addr;
  logic              beat_acc;
  logic              wlast_err;

  axs_burst_addr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_addr (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  assign axs_s0_awready = (state_q == ST_AW_READY);
  assign axs_s0_wready  = (state_q == ST_W_ACCEPT) & ~in_fifo_full;
  assign beat_acc       = axs_s0_wready & axs_s0_wvalid;
  assign in_fifo_push   = beat_acc;
  assign in_fifo_addr   = addr_q;
  assign axs_s0_bvalid  = (state_q == ST_B_VALID);
  assign axs_s0_bid     = id_q;
  assign axs_s0_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;

`ifdef WLAST_CHECK_EN
  assign wlast_err = beat_acc & (axs_s0_wlast != (cnt_q == '0));
`else
  logic unused_wlast;
  assign unused_wlast = axs_s0_wlast;
  assign wlast_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          id_q    <= '0;
          addr_q  <= '0;
          len_q   <= '0;
          cnt_q   <= '0;
          size_q  <= '0;
          burst_q <= '0;
          err_q   <= 1'b0;
          state_q <= ST_AW_READY;
        end
        ST_AW_READY: begin
          if (axs_s0_awvalid) begin
            id_q    <= axs_s0_awid;
            addr_q  <= axs_s0_awaddr;
            len_q   <= axs_s0_awlen;
            cnt_q   <= axs_s0_awlen;
            size_q  <= axs_s0_awsize;
            burst_q <= axs_s0_awburst;
            err_q   <= (axs_s0_awburst == BURST_RSVD);
            state_q <= ST_W_ACCEPT;
          end
        end
        ST_W_ACCEPT: begin
          if (beat_acc) begin
            if (wlast_err) err_q <= 1'b1;
            if (cnt_q == '0) begin
              state_q <= ST_B_VALID;
            end else begin
              cnt_q  <= cnt_q - LEN_W'(1);
              addr_q <= next_addr;
            end
          end
        end
        ST_B_VALID: begin
          if (axs_s0_bready) state_q <= ST_AW_READY;
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_axs_wr_fsm.sv
// Randomized bench for axs_wr_fsm against a transaction-level protocol/address model.
module tb_axs_wr_fsm;

  localparam int ID_W   = 4;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ID_W-1:0]   awid = '0;
  logic [ADDR_W-1:0] awaddr = '0;
  logic [LEN_W-1:0]  awlen = '0;
  logic [2:0]        awsize = '0;
  logic [1:0]        awburst = '0;
  logic              awvalid = 1'b0;
  logic              awready;
  logic              wlast = 1'b0;
  logic              wvalid = 1'b0;
  logic              wready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready = 1'b0;
  logic              full = 1'b0;
  logic              push;
  logic [ADDR_W-1:0] faddr;

  always #5 clk = ~clk;

  axs_wr_fsm #(.ID_W(ID_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk            (clk),
    .reset          (rst),
    .axs_s0_awid    (awid),
    .axs_s0_awaddr  (awaddr),
    .axs_s0_awlen   (awlen),
    .axs_s0_awsize  (awsize),
    .axs_s0_awburst (awburst),
    .axs_s0_awvalid (awvalid),
    .axs_s0_awready (awready),
    .axs_s0_wlast   (wlast),
    .axs_s0_wvalid  (wvalid),
    .axs_s0_wready  (wready),
    .axs_s0_bid     (bid),
    .axs_s0_bresp   (bresp),
    .axs_s0_bvalid  (bvalid),
    .axs_s0_bready  (bready),
    .in_fifo_full   (full),
    .in_fifo_push   (push),
    .in_fifo_addr   (faddr)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Model: a burst is a list of beat addresses computed up front; phases are plain flags.
  bit               m_init;
  bit               m_busy;
  bit               m_resp;
  logic [ID_W-1:0]  m_id;
  bit               m_err;
  logic [31:0]      m_q[$];
  logic [31:0]      pushlog[$];
  logic [1:0]       last_bresp;
  logic [ID_W-1:0]  last_bid;

  always @(negedge clk) begin : compare
    bit e_aw, e_wr, e_push;
    logic [31:0] step, wl, base, a;
    int beats;
    if (rst) begin
      chk("rst_awready", awready, 0);
      chk("rst_wready", wready, 0);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_push", push, 0);
      chk("rst_bid", bid, 0);
      chk("rst_bresp", bresp, 0);
      chk("rst_addr", faddr, 0);
      m_init = 1; m_busy = 0; m_resp = 0; m_err = 0;
      m_q.delete();
    end else begin
      e_aw   = !m_init && !m_busy && !m_resp;
      e_wr   = m_busy && !full;
      e_push = e_wr && wvalid;
      chk("awready", awready, e_aw);
      chk("wready", wready, e_wr);
      chk("push", push, e_push);
      chk("bvalid", bvalid, m_resp);
      if (push && e_push) begin
        chk("push_addr", faddr, m_q[0]);
        pushlog.push_back(faddr);
      end
      if (m_resp) begin
        chk("bid", bid, m_id);
        chk("bresp", bresp, m_err ? 2'b10 : 2'b00);
      end
      if (m_init) begin
        m_init = 0;
      end else if (e_aw && awvalid) begin
        m_busy = 1;
        m_id   = awid;
        m_err  = (awburst == 2'b11);
        beats  = int'(awlen) + 1;
        step   = 32'd1 << awsize;
        wl     = 32'(beats) * step;
        base   = (awaddr / wl) * wl;
        m_q.delete();
        for (int i = 0; i < beats; i++) begin
          case (awburst)
            2'b01:   a = awaddr + 32'(i) * step;
            2'b10:   a = base + ((awaddr - base + 32'(i) * step) % wl);
            default: a = awaddr;
          endcase
          m_q.push_back(a);
        end
      end else if (e_push) begin
`ifdef WLAST_CHECK_EN
        if (wlast != (m_q.size() == 1)) m_err = 1;
`endif
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_busy = 0;
          m_resp = 1;
        end
      end else if (m_resp && bready) begin
        m_resp     = 0;
        last_bresp = bresp;
        last_bid   = bid;
      end
    end
  end

  // mode 0: random valid/full; 1: clean streaming; 2: full for 3 cycles mid-burst.
  task automatic do_burst(input logic [ID_W-1:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bt, input int mode,
                          input int bad, input int bdelay);
    bit hs;
    int n;
    int b;
    if (mode == 0) begin
      repeat ($urandom_range(0, 2)) begin
        wvalid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bt; awvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      if (mode == 0) begin
        wvalid = 1'($urandom_range(0, 1));
        full   = 1'($urandom_range(0, 1));
      end
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0;
    chk("aw_handshake", hs, 1);
    b = 0; n = 0;
    while (b <= int'(len) && n < 3000) begin
      case (mode)
        0: begin wvalid = ($urandom_range(0, 3) != 0); full = ($urandom_range(0, 3) == 0); end
        2: begin wvalid = 1'b1; full = (n >= 1 && n <= 3); end
        default: begin wvalid = 1'b1; full = 1'b0; end
      endcase
      wlast = (b == int'(len)) ^ (b == bad);
      @(negedge clk); hs = wvalid && wready;
      @(posedge clk); #1; n++;
      if (hs) b++;
    end
    wvalid = 1'b0; wlast = 1'b0; full = 1'b0;
    chk("w_complete", b, int'(len) + 1);
    hs = 0; n = 0;
    while (!hs && n < 200) begin
      bready = (bdelay < 0) ? 1'($urandom_range(0, 1)) : (n >= bdelay);
      @(negedge clk); hs = bvalid && bready;
      @(posedge clk); #1; n++;
    end
    bready = 1'b0;
    chk("b_handshake", hs, 1);
  endtask

  initial begin
    logic [31:0] ra;
    logic [7:0]  rl;
    logic [2:0]  rs;
    logic [1:0]  rb;
    bit hs;
    int n;
    repeat (2) @(posedge clk); #1;
    chk("reset_awready_lit", awready, 0);
    chk("reset_addr_lit", faddr, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("init_to_awready_lit", awready, 1);

    pushlog.delete();
    do_burst(4'h5, 32'h100, 8'd0, 3'd2, 2'b01, 1, -1, 0);
    chk("single_cnt", pushlog.size(), 1);
    chk("single_addr", pushlog[0], 32'h100);
    chk("single_bid", last_bid, 4'h5);
    chk("single_bresp", last_bresp, 2'b00);

    pushlog.delete();
    do_burst(4'h3, 32'h1000, 8'd3, 3'd2, 2'b01, 1, -1, 0);
    chk("incr_cnt", pushlog.size(), 4);
    chk("incr_a0", pushlog[0], 32'h1000);
    chk("incr_a1", pushlog[1], 32'h1004);
    chk("incr_a2", pushlog[2], 32'h1008);
    chk("incr_a3", pushlog[3], 32'h100C);

    pushlog.delete();
    do_burst(4'h7, 32'h1008, 8'd3, 3'd2, 2'b10, 1, -1, 0);
    chk("wrap_a0", pushlog[0], 32'h1008);
    chk("wrap_a1", pushlog[1], 32'h100C);
    chk("wrap_a2", pushlog[2], 32'h1000);
    chk("wrap_a3", pushlog[3], 32'h1004);

    pushlog.delete();
    do_burst(4'h2, 32'h2000, 8'd3, 3'd2, 2'b01, 2, -1, 0);
    chk("full_cnt", pushlog.size(), 4);
    chk("full_a1", pushlog[1], 32'h2004);
    chk("full_a3", pushlog[3], 32'h200C);

    do_burst(4'hA, 32'h40, 8'd1, 3'd0, 2'b01, 1, -1, 5);
    chk("bdelay_bid", last_bid, 4'hA);

    pushlog.delete();
    do_burst(4'h6, 32'h500, 8'd1, 3'd2, 2'b11, 1, -1, 0);
    chk("rsvd_bresp", last_bresp, 2'b10);
    chk("rsvd_a1", pushlog[1], 32'h500);

    do_burst(4'h8, 32'h600, 8'd3, 3'd2, 2'b01, 1, 2, 0);
`ifdef WLAST_CHECK_EN
    chk("wlast_bresp", last_bresp, 2'b10);
`else
    chk("wlast_bresp", last_bresp, 2'b00);
`endif

    for (int k = 0; k < 40; k++) begin
      rb = 2'($urandom_range(0, 3));
      rs = 3'($urandom_range(0, 3));
      rl = (rb == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      ra = $urandom;
      if ($urandom_range(0, 4) == 0) ra = 32'hFFFF_FFC0 | (ra & 32'h3F);
      if (rb == 2'b10) ra = ra & ~((32'd1 << rs) - 1);
      do_burst(4'($urandom), ra, rl, rs, rb, 0,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15)) : -1, -1);
    end

    awid = 4'h9; awaddr = 32'h3000; awlen = 8'd7; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk); hs = awready;
      @(posedge clk); #1; n++;
    end
    awvalid = 1'b0; wvalid = 1'b1; full = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_reset_push_lit", push, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_wready", wready, 0);
    chk("mid_rst_push", push, 0);
    chk("mid_rst_bid", bid, 0);
    chk("mid_rst_addr", faddr, 0);
    chk("mid_rst_awready", awready, 0);
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_awready_lit", awready, 1);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
